// File: rtl/mult_pkg.sv
// Shared widths, types and limits for the Q8.8 pipelined multiplier.
// Saturating overflow is selected by defining MULT_SAT_EN.
package mult_pkg;

    localparam int DATA_W     = 16;
    localparam int FRAC_W     = 8;
    localparam int PROD_W     = 32;
    localparam int PIPE_DEPTH = 5;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    localparam data_t DATA_MAX = 16'sh7FFF;
    localparam data_t DATA_MIN = 16'sh8000;

    // Unsigned magnitude of a two's-complement word; 0x8000 maps to 32768.
    function automatic logic [DATA_W-1:0] mag_of(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] m;
        if (v[DATA_W-1]) begin
            m = ~v + 16'd1;
        end else begin
            m = v;
        end
        return m;
    endfunction

endpackage

// File: rtl/mult_pp8x8.sv
// Registered unsigned 8x8 -> 16 partial-product unit.
module mult_pp8x8 (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    logic [15:0] p_r;

    // Partial-product register, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_r <= 16'd0;
        end else begin
            p_r <= a * b;
        end
    end

    assign p = p_r;

endmodule

// File: rtl/mult.sv
// Five-stage signed Q8.8 multiplier: sign/magnitude split, 8x8 partial products,
// magnitude sum, sign restore, then shift by 8 with wrap or MULT_SAT_EN clamping.
module mult
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mac_in,
    input  logic [DATA_W-1:0] weight,
    output logic [DATA_W-1:0] mult_out
);

    logic              sign_s1_r, sign_s2_r, sign_s3_r;
    logic [DATA_W-1:0] mag_a_r, mag_b_r;
    logic [15:0]       pp_hh_s, pp_hl_s, pp_lh_s, pp_ll_s;
    logic [PROD_W-1:0] sum_s;
    logic [PROD_W-1:0] mag_s3_r;
    prod_t             prod_r;
    prod_t             shifted_s;
    logic [DATA_W-1:0] result_s;
    logic [DATA_W-1:0] mult_out_r;
    logic              unused_s;

    // S1: operand sign and magnitudes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_s1_r <= 1'b0;
            mag_a_r   <= 16'd0;
            mag_b_r   <= 16'd0;
        end else begin
            sign_s1_r <= mac_in[DATA_W-1] ^ weight[DATA_W-1];
            mag_a_r   <= mag_of(mac_in);
            mag_b_r   <= mag_of(weight);
        end
    end

    // S2: four registered partial products; the sign rides alongside.
    mult_pp8x8 u_pp_hh (.clk(clk), .reset(reset), .a(mag_a_r[15:8]), .b(mag_b_r[15:8]), .p(pp_hh_s));
    mult_pp8x8 u_pp_hl (.clk(clk), .reset(reset), .a(mag_a_r[15:8]), .b(mag_b_r[7:0]),  .p(pp_hl_s));
    mult_pp8x8 u_pp_lh (.clk(clk), .reset(reset), .a(mag_a_r[7:0]),  .b(mag_b_r[15:8]), .p(pp_lh_s));
    mult_pp8x8 u_pp_ll (.clk(clk), .reset(reset), .a(mag_a_r[7:0]),  .b(mag_b_r[7:0]),  .p(pp_ll_s));

    // S2 sign carry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_s2_r <= 1'b0;
        end else begin
            sign_s2_r <= sign_s1_r;
        end
    end

    // Max magnitude is 2^15 * 2^15, so the unsigned sum never carries out of 32 bits.
    assign sum_s = {pp_hh_s, 16'd0}
                 + {8'd0, pp_hl_s, 8'd0}
                 + {8'd0, pp_lh_s, 8'd0}
                 + {16'd0, pp_ll_s};

    // S3: magnitude sum; S4: restore the sign.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag_s3_r  <= 32'd0;
            sign_s3_r <= 1'b0;
            prod_r    <= 32'sd0;
        end else begin
            mag_s3_r  <= sum_s;
            sign_s3_r <= sign_s2_r;
            if (sign_s3_r) begin
                prod_r <= prod_t'(32'd0 - mag_s3_r);
            end else begin
                prod_r <= prod_t'(mag_s3_r);
            end
        end
    end

    assign shifted_s = prod_r >>> FRAC_W;

    // Fit the floor-rounded product into 16 bits.
    always_comb begin
        result_s = shifted_s[DATA_W-1:0];
`ifdef MULT_SAT_EN
        if (shifted_s > prod_t'(DATA_MAX)) begin
            result_s = DATA_MAX;
        end else if (shifted_s < prod_t'(DATA_MIN)) begin
            result_s = DATA_MIN;
        end else begin
            result_s = shifted_s[DATA_W-1:0];
        end
`else
        result_s = shifted_s[DATA_W-1:0];
`endif
    end

    // S5: output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mult_out_r <= 16'd0;
        end else begin
            mult_out_r <= result_s;
        end
    end

    assign mult_out = mult_out_r;

    // Fraction bits (and the high bits when wrapping) are discarded by design.
    assign unused_s = ^shifted_s;

endmodule

// File: tb/tb_mult.sv
// Directed-vector bench for the Q8.8 multiplier; expectations follow MULT_SAT_EN.
module tb_mult;

    typedef struct {
        logic [15:0] a;
        logic [15:0] w;
        logic [15:0] exp_wrap;
        logic [15:0] exp_sat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] mac_in = 16'h0000;
    logic [15:0] weight = 16'h0000;
    logic [15:0] mult_out;

    int tests = 0;
    int fails = 0;
    vec_t vecs[16];

    mult dut (
        .clk(clk),
        .reset(reset),
        .mac_in(mac_in),
        .weight(weight),
        .mult_out(mult_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pick(input vec_t v);
`ifdef MULT_SAT_EN
        return v.exp_sat;
`else
        return v.exp_wrap;
`endif
    endfunction

    initial begin
        vecs[0]  = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        vecs[1]  = '{16'h0280, 16'hFE80, 16'hFC40, 16'hFC40};
        vecs[2]  = '{16'h0001, 16'h0001, 16'h0000, 16'h0000};
        vecs[3]  = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[4]  = '{16'h7FFF, 16'h7FFF, 16'hFF00, 16'h7FFF};
        vecs[5]  = '{16'h8000, 16'h8000, 16'h0000, 16'h7FFF};
        vecs[6]  = '{16'h0100, 16'h0200, 16'h0200, 16'h0200};
        vecs[7]  = '{16'h0300, 16'hFF00, 16'hFD00, 16'hFD00};
        vecs[8]  = '{16'h0080, 16'h0080, 16'h0040, 16'h0040};
        vecs[9]  = '{16'hFF00, 16'hFF00, 16'h0100, 16'h0100};
        vecs[10] = '{16'h8000, 16'h0100, 16'h8000, 16'h8000};
        vecs[11] = '{16'h8000, 16'h7FFF, 16'h0080, 16'h8000};
        vecs[12] = '{16'h00FF, 16'h00FF, 16'h00FE, 16'h00FE};
        vecs[13] = '{16'hFF80, 16'h0080, 16'hFFC0, 16'hFFC0};
        vecs[14] = '{16'h0203, 16'h0405, 16'h0816, 16'h0816};
        vecs[15] = '{16'hFDFD, 16'h0405, 16'hF7E9, 16'hF7E9};

        // Reset held with nonzero operands: output stays zero.
        mac_in = 16'h0100;
        weight = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", mult_out, 16'h0000);
        end

        // Release: first pair at edge 1, result after edge 5, zeros before.
        reset = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                mac_in = 16'h0000;
                weight = 16'h0000;
            end
            if (c < 5) begin
                check("first_latency_zero", mult_out, 16'h0000);
            end else begin
                check("first_result", mult_out, 16'h0100);
            end
        end

        // Back-to-back table stream, one pair per edge.
        for (int c = 0; c < 21; c++) begin
            if (c >= 5) begin
                check($sformatf("vec%0d", c - 5), mult_out, pick(vecs[c - 5]));
            end
            if (c < 16) begin
                mac_in = vecs[c].a;
                weight = vecs[c].w;
            end else begin
                mac_in = 16'h0000;
                weight = 16'h0000;
            end
            @(negedge clk);
        end

        // Fill the pipe with 1.0 x 3.0 so the output and in-flight stages are nonzero.
        mac_in = 16'h0100;
        weight = 16'h0300;
        repeat (7) @(negedge clk);
        check("prefill", mult_out, 16'h0300);

        // Asynchronous reset between edges clears the output without a clock.
        @(posedge clk);
        #2;
        reset = 1'b0;
        mac_in = 16'h0000;
        weight = 16'h0000;
        #1;
        check("async_clear", mult_out, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check("reset_held", mult_out, 16'h0000);

        // Release with a fresh pair: in-flight 0x0300 results never emerge.
        reset = 1'b1;
        mac_in = 16'h0280;
        weight = 16'hFE80;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                mac_in = 16'h0000;
                weight = 16'h0000;
            end
            if (c == 5) begin
                check("post_reset_result", mult_out, 16'hFC40);
            end else begin
                check("post_reset_zero", mult_out, 16'h0000);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult.md
# mult

Five-stage pipelined signed fixed-point multiplier, the datapath core of the `mac` accumulator. It accepts one operand pair per clock with no handshake or stall. It returns the Q8.8 product of the data input and the weight exactly five clocks later. The `mac` block tracks that latency with its own stage flags and adds `mult_out` into its partial sum.

## Interface
Parameters: none; widths are fixed at 16 bits through the shared package.
- `clk`  input  1  single clock; all state changes on the rising edge
- `reset`  input  1  asynchronous, active-low; clears every pipeline register
- `mac_in`  input  16  data operand, signed two's-complement Q8.8
- `weight`  input  16  weight operand, signed two's-complement Q8.8
- `mult_out`  output  16  registered product, signed Q8.8

## Operation
- Operands are sampled on every rising edge. There is no enable, valid or stall signal. Throughput is one product per clock.
- Result = (`mac_in` × `weight`), computed as a full 32-bit signed product, then arithmetically shifted right by 8. This is floor rounding: truncation toward −∞.
- Overflow handling of the 16-bit result depends on `MULT_SAT_EN` (see Configuration).
- Pipeline stages:
  - S1: register the operands; derive the result sign (XOR of the MSBs) and the 16-bit unsigned magnitudes. |0x8000| = 32768 is representable.
  - S2: four 8×8 unsigned partial products (hi·hi, hi·lo, lo·hi, lo·lo), registered.
  - S3: shift and add the partial products into a 32-bit unsigned magnitude.
  - S4: apply the sign (two's-complement negate when the sign is set) to form the 32-bit signed product.
  - S5: arithmetic shift right by 8, saturate or wrap to 16 bits, register into `mult_out`.
- The sign bit travels alongside each stage, so operand pairs never mix.

## Timing
- Latency is 5 clocks. Operands sampled at edge k appear on `mult_out` immediately after edge k+4. Example: sampled at edge 1, visible after edge 5.
- Consecutive edges carry independent operand pairs; results emerge in order, one per clock.
- Reset (`reset` = 0) acts immediately, without waiting for a clock edge:
  - all stage registers clear;
  - `mult_out` = 0x0000.
- While reset is held, all outputs stay zero.
- After release, the first valid result appears 5 edges after the first sampled pair. Until then `mult_out` = 0x0000, because the cleared stages produce 0.
- Reset mid-operation: products already in flight are discarded and never emerge.

## Configuration
- `MULT_SAT_EN` defined:
  - a shifted result above 0x7FFF clamps to 0x7FFF;
  - a shifted result below −0x8000 clamps to 0x8000.
- `MULT_SAT_EN` undefined: `mult_out` takes the low 16 bits of the shifted result (wrap-around).
- Latency is 5 clocks either way.

## Structure
- Shared package `mult_pkg`:
  - `DATA_W` = 16, `FRAC_W` = 8, `PROD_W` = 32, `PIPE_DEPTH` = 5;
  - typedefs `data_t` (signed 16) and `prod_t` (signed 32);
  - saturation limits `DATA_MAX` = 0x7FFF and `DATA_MIN` = 0x8000.
- One sub-module, `mult_pp8x8`: an unsigned 8×8→16 registered partial-product unit, instantiated four times in S2.

## Test plan
- 0x0100 × 0x0100 (1.0 × 1.0) → 0x0100 on the 5th edge after sampling; 0x0000 on edges 1–4 after reset release.
- 0x0280 × 0xFE80 (2.5 × −1.5) → 0xFC40 (−3.75); 0x0001 × 0x0001 → 0x0000; 0x0001 × 0xFFFF → 0xFFFF (floor rounding).
- 0x7FFF × 0x7FFF and 0x8000 × 0x8000:
  - with `MULT_SAT_EN` → 0x7FFF for both;
  - without it → 0xFF00 and 0x0000 respectively.
- Back-to-back stream: 1.0×2.0, 3.0×−1.0, 0.5×0.5 on three consecutive edges → 0x0200, 0xFD00, 0x0040 on three consecutive edges, starting 5 edges later.
- Assert `reset` low asynchronously between edges while three products are in flight:
  - `mult_out` goes to 0x0000 immediately, with no clock edge;
  - none of the in-flight results ever appear after release;
  - the next operands sampled after release produce the correct result 5 edges later.
